// File: rtl/cobalt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cobalt_pkg
// Description : Shared constants and the reorder-buffer entry type used by the
//               rob top level and its operand lookup ports.
// Revision    : 1.0  initial release
// ============================================================================
package cobalt_pkg;

    localparam int TAG_W  = 6;
    localparam int DEPTH  = 1 << TAG_W;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    // One reorder-buffer slot. The entry index is the tag handed out at dispatch.
    typedef struct packed {
        logic              valid;
        logic              done;
        logic [REG_W-1:0]  rd;
        logic              regwrite;
        logic              isbranch;
        logic              taken;
        logic [DATA_W-1:0] data;
    } rob_entry_t;

endpackage : cobalt_pkg
`default_nettype wire

// File: rtl/rob_query.sv
`default_nettype none
// ============================================================================
// Module      : rob_query
// Description : Combinational operand lookup into one reorder-buffer entry,
//               with bypass from the CDB broadcast of the same cycle.
// Ports       : query_tag            - tag being looked up
//               entry_valid/done/data - fields of the entry selected by query_tag
//               cdb_valid/tagout/out - current CDB broadcast
//               query_ready          - operand value is available
//               query_data           - operand value
// Revision    : 1.0  initial release
// ============================================================================
module rob_query
    import cobalt_pkg::*;
(
    input  logic [TAG_W-1:0]  query_tag,
    input  logic              entry_valid,
    input  logic              entry_done,
    input  logic [DATA_W-1:0] entry_data,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tagout,
    input  logic [DATA_W-1:0] cdb_out,
    output logic              query_ready,
    output logic [DATA_W-1:0] query_data
);

    logic cdb_hit;

    // The CDB value is only meaningful for a live entry; a broadcast to a
    // free slot never makes an operand ready.
    assign cdb_hit     = cdb_valid && (cdb_tagout == query_tag);
    assign query_ready = entry_valid && (entry_done || cdb_hit);
    assign query_data  = cdb_hit ? cdb_out : entry_data;

endmodule : rob_query
`default_nettype wire

// File: rtl/rob.sv
`default_nettype none
// ============================================================================
// Module      : rob
// Description : Reorder buffer. Allocates one entry/tag per dispatched
//               instruction, captures CDB results, retires in program order
//               and flushes younger work when a taken branch commits.
// Ports       : clk, reset (async, active-low)
//               dispatch_* - allocation request, ready and next tag
//               cdb_*      - result broadcast
//               query_*    - two combinational operand lookup ports (rs, rt)
//               commit_*   - registered retire outputs, one-cycle pulses
// Revision    : 1.0  initial release
// ============================================================================
module rob
    import cobalt_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              dispatch_en,
    input  logic [REG_W-1:0]  dispatch_rd,
    input  logic              dispatch_regwrite,
    input  logic              dispatch_isbranch,
    output logic              dispatch_ready,
    output logic [TAG_W-1:0]  dispatch_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tagout,
    input  logic [DATA_W-1:0] cdb_out,
    input  logic              cdb_branch,
    input  logic              cdb_branch_taken,
    input  logic [TAG_W-1:0]  query_rstag,
    input  logic [TAG_W-1:0]  query_rttag,
    output logic              query_rsready,
    output logic              query_rtready,
    output logic [DATA_W-1:0] query_rsdata,
    output logic [DATA_W-1:0] query_rtdata,
    output logic              commit_en,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [REG_W-1:0]  commit_rd,
    output logic              commit_regwrite,
    output logic [DATA_W-1:0] commit_data,
    output logic              commit_flush
);

    localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);
    localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W+1)'(1);
    localparam logic [TAG_W:0]   CNT_FULL = (TAG_W+1)'(DEPTH);

    rob_entry_t        entries_q [DEPTH];
    rob_entry_t        entries_d [DEPTH];
    logic [TAG_W-1:0]  head_q, head_d;
    logic [TAG_W-1:0]  tail_q, tail_d;
    logic [TAG_W:0]    count_q, count_d;

    logic              commit_en_q, commit_en_d;
    logic [TAG_W-1:0]  commit_tag_q, commit_tag_d;
    logic [REG_W-1:0]  commit_rd_q, commit_rd_d;
    logic              commit_regwrite_q, commit_regwrite_d;
    logic [DATA_W-1:0] commit_data_q, commit_data_d;
    logic              commit_flush_q, commit_flush_d;

    rob_entry_t        head_entry;
    logic              commit_now;
    logic              flush_now;
    logic              alloc;

    assign head_entry = entries_q[head_q];
    assign commit_now = head_entry.valid && head_entry.done;
    assign flush_now  = commit_now && head_entry.isbranch && head_entry.taken;

    // No full-bypass: a commit in the same cycle does not open a slot early.
    assign dispatch_ready = (count_q != CNT_FULL) && !flush_now;
    assign dispatch_tag   = tail_q;
    assign alloc          = dispatch_en && dispatch_ready;

    always_comb begin
        entries_d         = entries_q;
        head_d            = head_q;
        tail_d            = tail_q;
        count_d           = count_q;
        commit_en_d       = 1'b0;
        commit_tag_d      = '0;
        commit_rd_d       = '0;
        commit_regwrite_d = 1'b0;
        commit_data_d     = '0;
        commit_flush_d    = 1'b0;

        if (alloc) begin
            entries_d[tail_q] = '{valid:    1'b1,
                                  done:     1'b0,
                                  rd:       dispatch_rd,
                                  regwrite: dispatch_regwrite,
                                  isbranch: dispatch_isbranch,
                                  taken:    1'b0,
                                  data:     '0};
            tail_d = tail_q + TAG_ONE;
        end

        // Tail is never valid, so a capture can not collide with the allocation.
        if (cdb_valid && entries_q[cdb_tagout].valid) begin
            entries_d[cdb_tagout].done  = 1'b1;
            entries_d[cdb_tagout].data  = cdb_out;
            entries_d[cdb_tagout].taken = cdb_branch && cdb_branch_taken;
        end

        if (commit_now) begin
            commit_en_d              = 1'b1;
            commit_tag_d             = head_q;
            commit_rd_d              = head_entry.rd;
            commit_regwrite_d        = head_entry.regwrite;
            commit_data_d            = head_entry.data;
            commit_flush_d           = flush_now;
            entries_d[head_q].valid  = 1'b0;
            head_d                   = head_q + TAG_ONE;
        end

        if (alloc && !commit_now) begin
            count_d = count_q + CNT_ONE;
        end else if (!alloc && commit_now) begin
            count_d = count_q - CNT_ONE;
        end

        // A taken branch discards everything younger, including any capture
        // landing on this edge. Allocation is already blocked by flush_now.
        if (flush_now) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].valid = 1'b0;
                entries_d[i].done  = 1'b0;
            end
            tail_d  = head_q + TAG_ONE;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q            <= '0;
            tail_q            <= '0;
            count_q           <= '0;
            commit_en_q       <= 1'b0;
            commit_tag_q      <= '0;
            commit_rd_q       <= '0;
            commit_regwrite_q <= 1'b0;
            commit_data_q     <= '0;
            commit_flush_q    <= 1'b0;
        end else begin
            entries_q         <= entries_d;
            head_q            <= head_d;
            tail_q            <= tail_d;
            count_q           <= count_d;
            commit_en_q       <= commit_en_d;
            commit_tag_q      <= commit_tag_d;
            commit_rd_q       <= commit_rd_d;
            commit_regwrite_q <= commit_regwrite_d;
            commit_data_q     <= commit_data_d;
            commit_flush_q    <= commit_flush_d;
        end
    end

    assign commit_en       = commit_en_q;
    assign commit_tag      = commit_tag_q;
    assign commit_rd       = commit_rd_q;
    assign commit_regwrite = commit_regwrite_q;
    assign commit_data     = commit_data_q;
    assign commit_flush    = commit_flush_q;

    rob_query u_query_rs (
        .query_tag   (query_rstag),
        .entry_valid (entries_q[query_rstag].valid),
        .entry_done  (entries_q[query_rstag].done),
        .entry_data  (entries_q[query_rstag].data),
        .cdb_valid   (cdb_valid),
        .cdb_tagout  (cdb_tagout),
        .cdb_out     (cdb_out),
        .query_ready (query_rsready),
        .query_data  (query_rsdata)
    );

    rob_query u_query_rt (
        .query_tag   (query_rttag),
        .entry_valid (entries_q[query_rttag].valid),
        .entry_done  (entries_q[query_rttag].done),
        .entry_data  (entries_q[query_rttag].data),
        .cdb_valid   (cdb_valid),
        .cdb_tagout  (cdb_tagout),
        .cdb_out     (cdb_out),
        .query_ready (query_rtready),
        .query_data  (query_rtdata)
    );

endmodule : rob
`default_nettype wire

// File: tb/tb_rob.sv
`default_nettype none
// ============================================================================
// Module      : tb_rob
// Description : Directed self-checking bench for the reorder buffer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rob;
    import cobalt_pkg::*;

    logic              clk;
    logic              reset;
    logic              dispatch_en;
    logic [REG_W-1:0]  dispatch_rd;
    logic              dispatch_regwrite;
    logic              dispatch_isbranch;
    logic              dispatch_ready;
    logic [TAG_W-1:0]  dispatch_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tagout;
    logic [DATA_W-1:0] cdb_out;
    logic              cdb_branch;
    logic              cdb_branch_taken;
    logic [TAG_W-1:0]  query_rstag;
    logic [TAG_W-1:0]  query_rttag;
    logic              query_rsready;
    logic              query_rtready;
    logic [DATA_W-1:0] query_rsdata;
    logic [DATA_W-1:0] query_rtdata;
    logic              commit_en;
    logic [TAG_W-1:0]  commit_tag;
    logic [REG_W-1:0]  commit_rd;
    logic              commit_regwrite;
    logic [DATA_W-1:0] commit_data;
    logic              commit_flush;

    int errors = 0;
    int checks = 0;

    rob dut (
        .clk               (clk),
        .reset             (reset),
        .dispatch_en       (dispatch_en),
        .dispatch_rd       (dispatch_rd),
        .dispatch_regwrite (dispatch_regwrite),
        .dispatch_isbranch (dispatch_isbranch),
        .dispatch_ready    (dispatch_ready),
        .dispatch_tag      (dispatch_tag),
        .cdb_valid         (cdb_valid),
        .cdb_tagout        (cdb_tagout),
        .cdb_out           (cdb_out),
        .cdb_branch        (cdb_branch),
        .cdb_branch_taken  (cdb_branch_taken),
        .query_rstag       (query_rstag),
        .query_rttag       (query_rttag),
        .query_rsready     (query_rsready),
        .query_rtready     (query_rtready),
        .query_rsdata      (query_rsdata),
        .query_rtdata      (query_rtdata),
        .commit_en         (commit_en),
        .commit_tag        (commit_tag),
        .commit_rd         (commit_rd),
        .commit_regwrite   (commit_regwrite),
        .commit_data       (commit_data),
        .commit_flush      (commit_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        dispatch_en       = 1'b0;
        dispatch_rd       = '0;
        dispatch_regwrite = 1'b0;
        dispatch_isbranch = 1'b0;
        cdb_valid         = 1'b0;
        cdb_tagout        = '0;
        cdb_out           = '0;
        cdb_branch        = 1'b0;
        cdb_branch_taken  = 1'b0;
        query_rstag       = '0;
        query_rttag       = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic alloc(input logic [REG_W-1:0] rd, input logic rw, input logic br);
        dispatch_rd       = rd;
        dispatch_regwrite = rw;
        dispatch_isbranch = br;
        dispatch_en       = 1'b1;
        tick();
        dispatch_en       = 1'b0;
    endtask

    task automatic cdb_send(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
        cdb_valid  = 1'b1;
        cdb_tagout = tag;
        cdb_out    = data;
        tick();
        cdb_valid  = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        #1;
        checks++; if (dispatch_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", dispatch_ready); end
        checks++; if (dispatch_tag !== 6'd0) begin errors++; $display("FAIL reset_tag: got %0d want 0", dispatch_tag); end
        tick();
        checks++; if ({commit_en, commit_flush, commit_regwrite} !== 3'b000) begin errors++; $display("FAIL reset_commit_flags: got %b want 000", {commit_en, commit_flush, commit_regwrite}); end
        checks++; if ({commit_tag, commit_rd, commit_data} !== '0) begin errors++; $display("FAIL reset_commit_fields: got %h/%h/%h want 0", commit_tag, commit_rd, commit_data); end
        reset = 1'b1;
    endtask

    task automatic test_single;
        do_reset();
        dispatch_rd = 5'd3; dispatch_regwrite = 1'b1; dispatch_isbranch = 1'b0; dispatch_en = 1'b1;
        #1;
        checks++; if (dispatch_tag !== 6'd0) begin errors++; $display("FAIL single_alloc_tag: got %0d want 0", dispatch_tag); end
        tick();
        dispatch_en = 1'b0;
        checks++; if (dispatch_tag !== 6'd1) begin errors++; $display("FAIL single_tail_advance: got %0d want 1", dispatch_tag); end
        cdb_send(6'd0, 32'h2);
        checks++; if (commit_en !== 1'b0) begin errors++; $display("FAIL single_early_commit: got %b want 0", commit_en); end
        tick();
        checks++; if (commit_en !== 1'b1 || commit_tag !== 6'd0 || commit_rd !== 5'd3) begin errors++; $display("FAIL single_commit: en=%b tag=%0d rd=%0d want en=1 tag=0 rd=3", commit_en, commit_tag, commit_rd); end
        checks++; if (commit_data !== 32'h2 || commit_regwrite !== 1'b1 || commit_flush !== 1'b0) begin errors++; $display("FAIL single_commit_data: data=%h rw=%b fl=%b want 2/1/0", commit_data, commit_regwrite, commit_flush); end
        tick();
        checks++; if (commit_en !== 1'b0 || commit_data !== 32'h0 || commit_regwrite !== 1'b0) begin errors++; $display("FAIL single_pulse_end: en=%b data=%h rw=%b want 0/0/0", commit_en, commit_data, commit_regwrite); end
    endtask

    task automatic test_out_of_order;
        logic [DATA_W-1:0] exp_data [3];
        exp_data[0] = 32'h100; exp_data[1] = 32'h11; exp_data[2] = 32'h22;
        do_reset();
        alloc(5'd10, 1'b1, 1'b0);
        alloc(5'd11, 1'b1, 1'b0);
        alloc(5'd12, 1'b1, 1'b0);
        cdb_send(6'd2, 32'h22);
        checks++; if (commit_en !== 1'b0) begin errors++; $display("FAIL ooo_no_commit_t2: got %b want 0", commit_en); end
        cdb_send(6'd1, 32'h11);
        checks++; if (commit_en !== 1'b0) begin errors++; $display("FAIL ooo_no_commit_t1: got %b want 0", commit_en); end
        cdb_send(6'd0, 32'h100);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (commit_en !== 1'b1 || commit_tag !== TAG_W'(k) || commit_rd !== REG_W'(10 + k) || commit_data !== exp_data[k]) begin
                errors++;
                $display("FAIL ooo_commit_%0d: en=%b tag=%0d rd=%0d data=%h want 1/%0d/%0d/%h", k, commit_en, commit_tag, commit_rd, commit_data, k, 10 + k, exp_data[k]);
            end
        end
        tick();
        checks++; if (commit_en !== 1'b0) begin errors++; $display("FAIL ooo_after: got %b want 0", commit_en); end
    endtask

    task automatic test_full;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            alloc(REG_W'(i), 1'b1, 1'b0);
        end
        checks++; if (dispatch_ready !== 1'b0 || dispatch_tag !== 6'd0) begin errors++; $display("FAIL full_ready: ready=%b tag=%0d want 0/0", dispatch_ready, dispatch_tag); end
        dispatch_rd = 5'd9; dispatch_en = 1'b1;
        cdb_send(6'd0, 32'h55);
        checks++; if (dispatch_tag !== 6'd0) begin errors++; $display("FAIL full_refused: tag=%0d want 0", dispatch_tag); end
        checks++; if (dispatch_ready !== 1'b0) begin errors++; $display("FAIL full_no_bypass: ready=%b want 0", dispatch_ready); end
        tick();
        dispatch_en = 1'b0;
        checks++; if (commit_en !== 1'b1 || commit_tag !== 6'd0 || commit_data !== 32'h55) begin errors++; $display("FAIL full_commit: en=%b tag=%0d data=%h want 1/0/55", commit_en, commit_tag, commit_data); end
        checks++; if (dispatch_ready !== 1'b1 || dispatch_tag !== 6'd0) begin errors++; $display("FAIL full_ready_back: ready=%b tag=%0d want 1/0", dispatch_ready, dispatch_tag); end
    endtask

    task automatic test_flush;
        logic exp_en;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            alloc(REG_W'(i + 1), (i != 5), (i == 5));
        end
        for (int k = 0; k < 8; k++) begin
            if (k == 6) begin
                checks++; if (dispatch_ready !== 1'b0) begin errors++; $display("FAIL flush_ready_low: got %b want 0", dispatch_ready); end
            end
            cdb_valid = 1'b1; cdb_tagout = TAG_W'(k); cdb_out = DATA_W'(16 * k + 1);
            cdb_branch = (k == 5); cdb_branch_taken = (k == 5);
            tick();
            cdb_valid = 1'b0; cdb_branch = 1'b0; cdb_branch_taken = 1'b0;
            exp_en = (k >= 1) && (k <= 6);
            checks++;
            if (commit_en !== exp_en) begin
                errors++; $display("FAIL flush_commit_en_%0d: got %b want %b", k, commit_en, exp_en);
            end else if (exp_en && (commit_tag !== TAG_W'(k - 1) || commit_flush !== (k == 6) || commit_regwrite !== (k != 6))) begin
                errors++; $display("FAIL flush_commit_%0d: tag=%0d fl=%b rw=%b want %0d/%b/%b", k, commit_tag, commit_flush, commit_regwrite, k - 1, (k == 6), (k != 6));
            end
            if (k == 6) begin
                checks++; if (dispatch_tag !== 6'd6 || dispatch_ready !== 1'b1) begin errors++; $display("FAIL flush_tail: tag=%0d ready=%b want 6/1", dispatch_tag, dispatch_ready); end
            end
        end
        tick();
        checks++; if (commit_en !== 1'b0) begin errors++; $display("FAIL flush_stale: got %b want 0", commit_en); end
        alloc(5'd20, 1'b1, 1'b0);
        cdb_send(6'd6, 32'h77);
        tick();
        checks++; if (commit_en !== 1'b1 || commit_tag !== 6'd6 || commit_rd !== 5'd20 || commit_data !== 32'h77 || commit_flush !== 1'b0) begin errors++; $display("FAIL flush_realloc: en=%b tag=%0d rd=%0d data=%h fl=%b want 1/6/20/77/0", commit_en, commit_tag, commit_rd, commit_data, commit_flush); end
    endtask

    task automatic test_bypass;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            alloc(REG_W'(i), 1'b1, 1'b0);
        end
        query_rstag = 6'd4; query_rttag = 6'd3;
        #1;
        checks++; if (query_rsready !== 1'b0 || query_rtready !== 1'b0) begin errors++; $display("FAIL bypass_pending: rs=%b rt=%b want 0/0", query_rsready, query_rtready); end
        cdb_valid = 1'b1; cdb_tagout = 6'd4; cdb_out = 32'hABCD;
        #1;
        checks++; if (query_rsready !== 1'b1 || query_rsdata !== 32'hABCD) begin errors++; $display("FAIL bypass_hit: ready=%b data=%h want 1/abcd", query_rsready, query_rsdata); end
        checks++; if (query_rtready !== 1'b0) begin errors++; $display("FAIL bypass_other: ready=%b want 0", query_rtready); end
        tick();
        cdb_valid = 1'b0;
        #1;
        checks++; if (query_rsready !== 1'b1 || query_rsdata !== 32'hABCD) begin errors++; $display("FAIL bypass_stored: ready=%b data=%h want 1/abcd", query_rsready, query_rsdata); end
        query_rttag = 6'd10; cdb_valid = 1'b1; cdb_tagout = 6'd10; cdb_out = 32'h1234;
        #1;
        checks++; if (query_rtready !== 1'b0) begin errors++; $display("FAIL bypass_invalid: ready=%b want 0", query_rtready); end
        cdb_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            alloc(REG_W'(i), 1'b1, 1'b0);
        end
        cdb_send(6'd0, 32'h99);
        reset = 1'b0;
        #1;
        checks++; if (dispatch_ready !== 1'b1 || dispatch_tag !== 6'd0) begin errors++; $display("FAIL midreset_ptrs: ready=%b tag=%0d want 1/0", dispatch_ready, dispatch_tag); end
        tick();
        reset = 1'b1;
        checks++; if (commit_en !== 1'b0 || commit_data !== 32'h0) begin errors++; $display("FAIL midreset_commit: en=%b data=%h want 0/0", commit_en, commit_data); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (commit_en !== 1'b0) begin errors++; $display("FAIL midreset_no_commit_%0d: got %b want 0", k, commit_en); end
        end
        query_rstag = 6'd0;
        #1;
        checks++; if (query_rsready !== 1'b0) begin errors++; $display("FAIL midreset_query: got %b want 0", query_rsready); end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_single();
        test_out_of_order();
        test_full();
        test_flush();
        test_bypass();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_rob
`default_nettype wire
